wishbone_ram_slave: RTL and testbench

//  Wishbone B4 classic (non-pipelined) slave.

---
 rtl/argon_wb_pkg.sv | 19 +
 rtl/wishbone_if.sv | 20 ++
 rtl/byte_enable_ram.sv | 34 +++
 rtl/wishbone_ram_slave.sv | 160 ++++++++++++++++
 tb/tb_wishbone_ram_slave.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/argon_wb_pkg.sv
// argon_wb_pkg: Wishbone bus widths shared by the Argon SoC masters and slaves,
// plus the state type of the RAM slave controller.
package argon_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_SEL_W  = 4;
    localparam int WB_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } wb_ram_state_t;

    function automatic bit is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/wishbone_if.sv
// wishbone_if: Wishbone B4 classic bus bundle with master and slave views.
interface wishbone_if;
    import argon_wb_pkg::*;

    logic                 cyc;
    logic                 stb;
    logic                 we;
    logic [WB_SEL_W-1:0]  sel;
    logic [WB_ADDR_W-1:0] adr;
    logic [WB_DATA_W-1:0] dat_m2s;
    logic [WB_DATA_W-1:0] dat_s2m;
    logic                 ack;
    logic                 err;

    modport slave  (input  cyc, stb, we, sel, adr, dat_m2s,
                    output dat_s2m, ack, err);
    modport master (output cyc, stb, we, sel, adr, dat_m2s,
                    input  dat_s2m, ack, err);

endinterface

// File: rtl/byte_enable_ram.sv
// byte_enable_ram: single-port word RAM, synchronous read, per-byte write enables.
// Written so synthesis tools map it onto block RAM.
module byte_enable_ram
    import argon_wb_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int          ADDR_W      = 12,
    parameter string       INIT_FILE   = ""
) (
    input  logic                 clk,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [WB_SEL_W-1:0]  we,
    input  logic [WB_DATA_W-1:0] wdata,
    output logic [WB_DATA_W-1:0] rdata
);

    if (INIT_FILE != "") begin : g_init_note
        $warning("byte_enable_ram: INIT_FILE preload is applied by the implementation flow");
    end

    logic [WB_DATA_W-1:0] mem [DEPTH_WORDS];

    // NOTE: the array has no reset branch; clearing it would block RAM inference
    // and reset must leave memory contents intact anyway.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WB_SEL_W; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/wishbone_ram_slave.sv
// wishbone_ram_slave: Wishbone B4 classic slave fronting a byte-lane RAM with
// WAIT_STATES extra cycles per access. Define WB_RAM_ERR_EN to answer out-of-range accesses with err.
module wishbone_ram_slave
    import argon_wb_pkg::*;
#(
    parameter int unsigned          DEPTH_WORDS = 4096,
    parameter logic [WB_ADDR_W-1:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned          WAIT_STATES = 1,
    parameter string                INIT_FILE   = ""
) (
    input  logic      clk,
    input  logic      reset,
    wishbone_if.slave wb_slave
);

    localparam int         AW      = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [3:0] WS_LOAD = 4'(WAIT_STATES);

    if (!is_pow2(DEPTH_WORDS)) begin : g_bad_depth
        $error("wishbone_ram_slave: DEPTH_WORDS must be a power of two");
    end
    if ((BASE_ADDR % (DEPTH_WORDS * 4)) != 0) begin : g_bad_base
        $error("wishbone_ram_slave: BASE_ADDR must be aligned to DEPTH_WORDS*4");
    end
    if (WAIT_STATES > 15) begin : g_bad_ws
        $error("wishbone_ram_slave: WAIT_STATES must be 0..15");
    end

    wb_ram_state_t        state, next_state;
    logic [3:0]           wait_cnt, next_cnt;
    logic                 ack_q;
    logic                 accept, resp_go, commit;
    logic [WB_ADDR_W-1:0] offset;
    logic [AW-1:0]        bus_idx, cur_idx;
    logic                 bus_bad, cur_bad;
    logic                 req_we;
    logic [WB_SEL_W-1:0]  req_sel;
    logic [WB_DATA_W-1:0] req_dat;
    logic [AW-1:0]        req_idx;
    logic                 req_bad;
    logic [WB_SEL_W-1:0]  ram_we;
    logic [WB_DATA_W-1:0] ram_rdata;
    logic                 unused_offset;

    assign offset  = wb_slave.adr - BASE_ADDR;
    assign bus_idx = offset[AW+1:2];

`ifdef WB_RAM_ERR_EN
    assign bus_bad       = (wb_slave.adr < BASE_ADDR) || ((offset >> (AW + 2)) != '0);
    assign unused_offset = ^offset[1:0];
`else
    // Upper offset bits are dropped so the index wraps modulo DEPTH_WORDS.
    assign bus_bad       = 1'b0;
    assign unused_offset = ^{offset[WB_ADDR_W-1:AW+2], offset[1:0]};
`endif

    assign accept = (state == IDLE) && wb_slave.cyc && wb_slave.stb;

    // When going straight from IDLE to RESP the latches are not loaded yet, so use the bus.
    assign cur_idx = (state == IDLE) ? bus_idx : req_idx;
    assign cur_bad = (state == IDLE) ? bus_bad : req_bad;

    // NOTE: every output of this block gets a default before the case, so no
    // path can leave one unassigned and infer a latch.
    always_comb begin
        next_state = state;
        next_cnt   = wait_cnt;
        resp_go    = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (accept) begin
                    next_cnt = WS_LOAD;
                    if (WAIT_STATES == 0) begin
                        next_state = RESP;
                        resp_go    = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!wb_slave.cyc) begin
                    next_state = IDLE;
                    next_cnt   = '0;
                end else if (wait_cnt == 4'd1) begin
                    next_state = RESP;
                    next_cnt   = '0;
                    resp_go    = 1'b1;
                end else begin
                    next_cnt = wait_cnt - 4'd1;
                end
            end
            RESP: begin
                next_state = IDLE;
                commit     = wb_slave.cyc && req_we && !req_bad;
            end
            default: next_state = IDLE;
        endcase
    end

    // NOTE: registers take non-blocking assignments so every flop samples the
    // pre-edge values regardless of the order the blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
            ack_q    <= 1'b0;
        end else begin
            state    <= next_state;
            wait_cnt <= next_cnt;
            ack_q    <= resp_go && !cur_bad;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            req_we  <= wb_slave.we;
            req_sel <= wb_slave.sel;
            req_dat <= wb_slave.dat_m2s;
            req_idx <= bus_idx;
            req_bad <= bus_bad;
        end
    end

    // The write lands on the edge that closes the ACK cycle; reset on that edge discards it.
    assign ram_we = (commit && !reset) ? req_sel : '0;

    byte_enable_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (AW),
        .INIT_FILE   (INIT_FILE)
    ) u_ram (
        .clk   (clk),
        .addr  (cur_idx),
        .we    (ram_we),
        .wdata (req_dat),
        .rdata (ram_rdata)
    );

    assign wb_slave.ack     = ack_q;
    assign wb_slave.dat_s2m = (ack_q && !req_we) ? ram_rdata : '0;

`ifdef WB_RAM_ERR_EN
    logic err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            err_q <= 1'b0;
        end else begin
            err_q <= resp_go && cur_bad;
        end
    end

    assign wb_slave.err = err_q;
`else
    assign wb_slave.err = 1'b0;
`endif

endmodule

// File: tb/tb_wishbone_ram_slave.sv
// tb_wishbone_ram_slave: two slaves (WAIT_STATES=1 and 0, 16 words each) driven by
// directed transfers; a transaction-level model predicts every bus cycle's outputs.
module tb_wishbone_ram_slave;

    localparam int DEPTH = 16;
`ifdef WB_RAM_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        m_cyc [2];
    logic        m_stb [2];
    logic        m_we  [2];
    logic [3:0]  m_sel [2];
    logic [31:0] m_adr [2];
    logic [31:0] m_dat [2];
    logic        s_ack [2];
    logic        s_err [2];
    logic [31:0] s_dat [2];

    wishbone_if wb0 ();
    wishbone_if wb1 ();

    assign wb0.cyc = m_cyc[0];  assign wb1.cyc = m_cyc[1];
    assign wb0.stb = m_stb[0];  assign wb1.stb = m_stb[1];
    assign wb0.we  = m_we[0];   assign wb1.we  = m_we[1];
    assign wb0.sel = m_sel[0];  assign wb1.sel = m_sel[1];
    assign wb0.adr = m_adr[0];  assign wb1.adr = m_adr[1];
    assign wb0.dat_m2s = m_dat[0];  assign wb1.dat_m2s = m_dat[1];
    assign s_ack[0] = wb0.ack;  assign s_ack[1] = wb1.ack;
    assign s_err[0] = wb0.err;  assign s_err[1] = wb1.err;
    assign s_dat[0] = wb0.dat_s2m;  assign s_dat[1] = wb1.dat_s2m;

    wishbone_ram_slave #(
        .DEPTH_WORDS (DEPTH), .BASE_ADDR (32'h0), .WAIT_STATES (1), .INIT_FILE ("")
    ) u_dut0 (.clk (clk), .reset (reset), .wb_slave (wb0));

    wishbone_ram_slave #(
        .DEPTH_WORDS (DEPTH), .BASE_ADDR (32'h0), .WAIT_STATES (0), .INIT_FILE ("")
    ) u_dut1 (.clk (clk), .reset (reset), .wb_slave (wb1));

    function automatic int ws_of(input int d);
        return (d == 0) ? 1 : 0;
    endfunction

    // Model: memory image per slave plus the single response each slave owes.
    logic [31:0] mem_m [2][DEPTH];
    int          resp_cycle [2];
    bit          resp_is_err [2];
    logic [31:0] resp_dat [2];
    int          last_resp [2];

    int cnt = 0;
    always @(posedge clk) cnt <= cnt + 1;

    int vectors = 0;
    int miscompares = 0;
    bit cmp_en = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Per-cycle compare of {ack, err, dat_s2m} against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            for (int d = 0; d < 2; d++) begin
                bit          hit;
                bit          ea, ee;
                logic [31:0] ed;
                hit = (cnt == resp_cycle[d]);
                ea  = hit && !resp_is_err[d];
                ee  = hit && resp_is_err[d];
                ed  = ea ? resp_dat[d] : 32'h0;
                check($sformatf("bus%0d_cycle%0d", d, cnt),
                      {30'b0, s_ack[d], s_err[d], s_dat[d]},
                      {30'b0, ea, ee, ed});
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One classic transfer; called just after a rising edge. hold keeps cyc/stb up afterwards.
    task automatic xfer(input int d, input bit we, input logic [31:0] adr,
                        input logic [3:0] sel, input logic [31:0] dat, input bit hold,
                        output logic [31:0] rd, output int ack_cyc, output int lat,
                        output bit saw_err);
        int acc, word, idx;
        bit bad;
        m_cyc[d] = 1'b1; m_stb[d] = 1'b1; m_we[d] = we;
        m_adr[d] = adr;  m_sel[d] = sel;  m_dat[d] = dat;
        acc  = (cnt + 1 > last_resp[d] + 2) ? cnt + 1 : last_resp[d] + 2;
        word = int'(adr >> 2);
        bad  = ERR_EN && (word >= DEPTH);
        idx  = word % DEPTH;
        resp_cycle[d]  = acc + ws_of(d);
        resp_is_err[d] = bad;
        resp_dat[d]    = (we || bad) ? 32'h0 : mem_m[d][idx];
        rd = 'x; ack_cyc = -1; saw_err = 1'b0;
        for (int i = 0; i < 32; i++) begin
            @(negedge clk);
            if (s_ack[d] || s_err[d]) begin
                rd = s_dat[d]; ack_cyc = cnt; saw_err = s_err[d];
                break;
            end
        end
        if (ack_cyc < 0) begin
            vectors++; miscompares++;
            $display("FAIL timeout bus%0d adr %h: no ack/err within 32 cycles", d, adr);
        end
        lat = ack_cyc + 1 - acc;
        if (we && !bad) begin
            for (int b = 0; b < 4; b++) begin
                if (sel[b]) mem_m[d][idx][8*b +: 8] = dat[8*b +: 8];
            end
        end
        last_resp[d] = resp_cycle[d];
        tick();
        if (!hold) begin
            m_cyc[d] = 1'b0; m_stb[d] = 1'b0;
        end
    endtask

    logic [31:0] rd;
    int          ac0, ac1, lat;
    bit          se;
    int          c;

    initial begin
        for (int d = 0; d < 2; d++) begin
            resp_cycle[d] = -1; last_resp[d] = -100;
            m_cyc[d] = 1'b0; m_stb[d] = 1'b0; m_we[d] = 1'b0;
            m_sel[d] = 4'h0; m_adr[d] = 32'h0; m_dat[d] = 32'h0;
        end
        reset = 1'b1;
        @(posedge clk);
        cmp_en = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;

        // Known image in both RAMs: word i = A500_000i
        for (int i = 0; i < DEPTH; i++) begin
            for (int d = 0; d < 2; d++) begin
                xfer(d, 1'b1, 32'(i * 4), 4'hF, 32'hA500_0000 | 32'(i), 1'b0, rd, ac0, lat, se);
            end
        end

        // Write/read with one wait state: ack sampled two edges after accept
        xfer(0, 1'b1, 32'h10, 4'hF, 32'hDEAD_BEEF, 1'b0, rd, ac0, lat, se);
        check("t1_wr_latency", lat, 2);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, ac0, lat, se);
        check("t1_rd_latency", lat, 2);
        check("t1_rd_data", rd, 32'hDEAD_BEEF);

        // Byte lanes 0 and 2 only
        xfer(0, 1'b1, 32'h10, 4'b0101, 32'h1122_3344, 1'b0, rd, ac0, lat, se);
        xfer(0, 1'b0, 32'h10, 4'hF, 32'h0, 1'b0, rd, ac0, lat, se);
        check("t2_lane_merge", rd, 32'hDE22_BE44);

        // Zero wait states, stb held: back-to-back reads
        xfer(1, 1'b0, 32'h0, 4'hF, 32'h0, 1'b1, rd, ac0, lat, se);
        check("t3_rd0_data", rd, 32'hA500_0000);
        check("t3_rd0_latency", lat, 1);
        xfer(1, 1'b0, 32'h4, 4'hF, 32'h0, 1'b0, rd, ac1, lat, se);
        check("t3_rd1_data", rd, 32'hA500_0001);
        check("t3_ack_spacing", ac1 - ac0, 2);

        // Held write then read of the same word returns the new data
        xfer(1, 1'b1, 32'h8, 4'b1100, 32'hCAFE_BABE, 1'b1, rd, ac0, lat, se);
        xfer(1, 1'b0, 32'h8, 4'hF, 32'h0, 1'b0, rd, ac0, lat, se);
        check("t3_raw_data", rd, 32'hCAFE_0002);

        // sel=0 write is acknowledged but changes nothing
        xfer(1, 1'b1, 32'hC, 4'b0000, 32'hFFFF_FFFF, 1'b0, rd, ac0, lat, se);
        xfer(1, 1'b0, 32'hC, 4'hF, 32'h0, 1'b0, rd, ac0, lat, se);
        check("t3_sel0_data", rd, 32'hA500_0003);

        // cyc dropped while in WAIT: no ack, no write
        c = cnt;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 32'h20; m_sel[0] = 4'hF; m_dat[0] = 32'hBAD0_BAD0;
        resp_cycle[0] = -1;
        tick();
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        tick();
        last_resp[0] = c;
        tick();
        xfer(0, 1'b0, 32'h20, 4'hF, 32'h0, 1'b0, rd, ac0, lat, se);
        check("t4_abort_data", rd, 32'hA500_0008);

        // Reset while the write sits in RESP: ack clears, word keeps old value
        c = cnt;
        m_cyc[0] = 1'b1; m_stb[0] = 1'b1; m_we[0] = 1'b1;
        m_adr[0] = 32'h24; m_sel[0] = 4'hF; m_dat[0] = 32'h1234_5678;
        resp_cycle[0] = c + 2; resp_is_err[0] = 1'b0; resp_dat[0] = 32'h0;
        tick();
        tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_cyc[0] = 1'b0; m_stb[0] = 1'b0;
        check("t5_ack_cleared", {31'b0, s_ack[0]}, 0);
        last_resp[0] = c + 2;
        tick();
        xfer(0, 1'b0, 32'h24, 4'hF, 32'h0, 1'b0, rd, ac0, lat, se);
        check("t5_word_kept", rd, 32'hA500_0009);

        // Word index 16 on a 16-word RAM
        xfer(0, 1'b0, 32'h40, 4'hF, 32'h0, 1'b0, rd, ac0, lat, se);
`ifdef WB_RAM_ERR_EN
        check("t6_err_seen", {31'b0, se}, 1);
        check("t6_err_data", rd, 32'h0);
`else
        check("t6_err_seen", {31'b0, se}, 0);
        check("t6_wrap_data", rd, 32'hA500_0000);
`endif

        repeat (3) tick();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
